viterbi_decoder: RTL and testbench

- Hard-decision Viterbi decoder for the team's rate-1/2, constraint-length-3 convolutional code; receive-side counterpart of the encoder.
- Accepts one received symbol pair per `sym_valid` cycle and updates four path metrics by add-compare-select (ACS).
- Keeps survivor paths in a register-exchange memory and emits one decoded bit per accepted pair after a fixed traceback depth.
- Sits between the PRML channel detector output and the downstream bit sink.

---
 rtl/vdec_pkg.sv | 24 ++
 rtl/vdec_acs.sv | 22 ++
 rtl/viterbi_decoder.sv | 127 ++++++++++++
 tb/tb_viterbi_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vdec_pkg.sv
// Code constants and helpers for the rate-1/2, K=3 hard-decision Viterbi decoder.
// State encoding is {a,c}: a = previous data bit, c = the bit before it.
package vdec_pkg;

    localparam int         NUM_STATES = 4;
    localparam logic [2:0] G0         = 3'b110;
    localparam logic [2:0] G1         = 3'b111;

    typedef logic [1:0] vstate_t;

    // Expected {p0,p1} when data bit b leaves state s; register order is {b,a,c}.
    function automatic logic [1:0] exp_sym(input vstate_t s, input logic b);
        logic [2:0] r;
        r = {b, s};
        return {^(r & G0), ^(r & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] d;
        d = x ^ y;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/vdec_acs.sv
// Add-compare-select for one next state: picks the cheaper of its two predecessors.
module vdec_acs #(
    parameter int PM_W = 5
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bm0_i,
    input  logic [1:0]      bm1_i,
    output logic [PM_W:0]   pm_o,
    output logic            dec_o
);

    logic [PM_W:0] cand0, cand1;

    assign cand0 = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0_i};
    assign cand1 = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1_i};

    // Ties go to the c=0 predecessor.
    assign dec_o = (cand1 < cand0);
    assign pm_o  = dec_o ? cand1 : cand0;

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, register-exchange survivors, one bit per accepted pair.
// Define VDEC_ERRCNT_EN to add the err_count port (sum of best-path branch metrics).
module viterbi_decoder
    import vdec_pkg::*;
#(
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sym_valid,
    input  logic [1:0]  sym,
    output logic        out_valid,
`ifdef VDEC_ERRCNT_EN
    output logic        out_bit,
    output logic [15:0] err_count
`else
    output logic        out_bit
`endif
);

    localparam logic [PM_W:0]   PM_MAX   = {1'b0, {PM_W{1'b1}}};
    localparam logic [PM_W-1:0] PM_HALF  = {1'b1, {(PM_W-1){1'b0}}};
    localparam logic [5:0]      FILL_MAX = 6'(TB_DEPTH);

    logic [NUM_STATES-1:0][PM_W-1:0]     pm_q, pm_d;
    logic [NUM_STATES-1:0][TB_DEPTH-1:0] surv_q, surv_d;
    logic [NUM_STATES-1:0][PM_W:0]       acs_new;
    logic [NUM_STATES-1:0]               dec;
    logic [NUM_STATES-1:0]               shout;
    logic [PM_W:0]                       min_new, diff;
    vstate_t                             best;
    logic                                dec_bit;
    logic [5:0]                          fill_q;
    logic                                out_valid_q, out_bit_q;

    genvar n;
    generate
        for (n = 0; n < NUM_STATES; n++) begin : g_state
            // Next state n = {b,a}; its predecessors are {a,0} and {a,1}.
            localparam int      A  = n % 2;
            localparam logic    NB = (n / 2) != 0;
            localparam vstate_t P0 = vstate_t'(2 * A);
            localparam vstate_t P1 = vstate_t'(2 * A + 1);

            logic [1:0] bm0, bm1;

            assign bm0 = hamming2(sym, exp_sym(P0, NB));
            assign bm1 = hamming2(sym, exp_sym(P1, NB));

            vdec_acs #(.PM_W(PM_W)) u_acs (
                .pm0_i (pm_q[P0]),
                .pm1_i (pm_q[P1]),
                .bm0_i (bm0),
                .bm1_i (bm1),
                .pm_o  (acs_new[n]),
                .dec_o (dec[n])
            );

            assign surv_d[n] = dec[n] ? {surv_q[P1][TB_DEPTH-2:0], NB}
                                      : {surv_q[P0][TB_DEPTH-2:0], NB};
            // The bit pushed out of the winning path is the one TB_DEPTH pairs old.
            assign shout[n]  = dec[n] ? surv_q[P1][TB_DEPTH-1] : surv_q[P0][TB_DEPTH-1];
        end
    endgenerate

    always_comb begin
        min_new = acs_new[0];
        for (int i = 1; i < NUM_STATES; i++)
            if (acs_new[i] < min_new) min_new = acs_new[i];

        best = '0;
        for (int i = NUM_STATES - 1; i >= 0; i--)
            if (acs_new[i] == min_new) best = vstate_t'(i);

        diff = '0;
        pm_d = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            diff    = acs_new[i] - min_new;
            pm_d[i] = (diff > PM_MAX) ? PM_MAX[PM_W-1:0] : diff[PM_W-1:0];
        end

        dec_bit = shout[best];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pm_q        <= {PM_HALF, PM_HALF, PM_HALF, {PM_W{1'b0}}};
            surv_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (sym_valid) begin
                pm_q   <= pm_d;
                surv_q <= surv_d;
                if (fill_q == FILL_MAX) begin
                    out_valid_q <= 1'b1;
                    out_bit_q   <= dec_bit;
                end else begin
                    fill_q <= fill_q + 6'd1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;

`ifdef VDEC_ERRCNT_EN
    logic [15:0] errcnt_q, errcnt_d;
    logic [16:0] err_sum;

    // Stored minimum is always 0, so the new raw minimum is the best-path BM.
    assign err_sum  = {1'b0, errcnt_q} + 17'(min_new);
    assign errcnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         errcnt_q <= '0;
        else if (sym_valid) errcnt_q <= errcnt_d;
    end

    assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: expected bits queued as pairs are driven.
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 15;

    logic       clock = 1'b0;
    logic       reset;
    logic       sym_valid;
    logic [1:0] sym;
    logic       out_valid;
    logic       out_bit;
`ifdef VDEC_ERRCNT_EN
    logic [15:0] err_count;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   pairs_since_rst = 0;
    int   strobes = 0;
    bit   exp_q[$];
    bit   data_a[256];
    logic [1:0] err_a[256];

    always #5 clock = ~clock;

    viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .sym_valid (sym_valid),
        .sym       (sym),
        .out_valid (out_valid),
`ifdef VDEC_ERRCNT_EN
        .out_bit   (out_bit),
        .err_count (err_count)
`else
        .out_bit   (out_bit)
`endif
    );

    // Reference encoder, state {a,c}: p0 = b^a, p1 = b^a^c.
    function automatic logic [1:0] enc(input logic [1:0] st, input bit b);
        return {b ^ st[1], b ^ st[1] ^ st[0]};
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < 256; i++) begin
            data_a[i] = 1'b0;
            err_a[i]  = 2'b00;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        sym_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        pairs_since_rst = 0;
        strobes = 0;
        exp_q.delete();
    endtask

    // Drives one pair (called at a negedge) and checks the strobe it should cause.
    task automatic send(input logic [1:0] s, input bit push, input bit eb, input int gap);
        bit want;
        if (push) exp_q.push_back(eb);
        sym = s;
        sym_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        sym_valid = 1'b0;
        checks++;
        if (out_valid !== push) begin
            failures++;
            $display("FAIL strobe pair=%0d out_valid=%b expected=%b", pairs_since_rst, out_valid, push);
        end
        if (out_valid === 1'b1) begin
            strobes++;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                if (out_bit !== want) begin
                    failures++;
                    $display("FAIL out_bit pair=%0d got=%b expected=%b", pairs_since_rst, out_bit, want);
                end
            end
        end
        pairs_since_rst++;
        repeat (gap) begin
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_strobe pair=%0d out_valid=%b expected=0", pairs_since_rst, out_valid);
            end
        end
    endtask

    // Encodes data_a[0..n-1] plus TB_DEPTH tail zeros from state 00, applying err_a.
    task automatic run_stream(input int n, input int gap, input string name);
        logic [1:0] st;
        bit b;
        st = 2'b00;
        for (int k = 0; k < n + TB_DEPTH; k++) begin
            b = (k < n) ? data_a[k] : 1'b0;
            send(enc(st, b) ^ err_a[k], k >= TB_DEPTH, (k >= TB_DEPTH) ? data_a[k - TB_DEPTH] : 1'b0, gap);
            st = {b, st[1]};
        end
        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending left=%0d expected=0", name, exp_q.size());
        end
        checks++;
        if (strobes != n) begin
            failures++;
            $display("FAIL %s_strobes got=%0d expected=%0d", name, strobes, n);
        end
    endtask

    task automatic check_err(input int want, input string name);
`ifdef VDEC_ERRCNT_EN
        checks++;
        if (err_count !== 16'(want)) begin
            failures++;
            $display("FAIL %s_err_count got=%0d expected=%0d", name, err_count, want);
        end
`else
        if (want < 0) $display("note: %s", name);
`endif
    endtask

    task automatic test_clean();
        do_reset();
        clear_stim();
        data_a[0] = 1; data_a[1] = 0; data_a[2] = 1; data_a[3] = 1;
        run_stream(4, 0, "clean");
        check_err(0, "clean");
    endtask

    task automatic test_reset();
        // Previous stream left out_bit = 1; reset must clear it even with sym_valid high.
        @(negedge clock);
        reset = 1'b0;
        sym_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sym = 2'(i);
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0 || out_bit !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs got=%b%b expected=00", out_valid, out_bit);
            end
        end
        sym_valid = 1'b0;
        reset = 1'b1;
        pairs_since_rst = 0;
        strobes = 0;
        exp_q.delete();
        check_err(0, "reset");
        for (int k = 0; k < TB_DEPTH; k++) send(2'b00, 1'b0, 1'b0, 0);
        checks++;
        if (strobes != 0) begin
            failures++;
            $display("FAIL reset_fill_strobes got=%0d expected=0", strobes);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        clear_stim();
        data_a[0] = 1; data_a[1] = 0; data_a[2] = 1; data_a[3] = 1;
        err_a[1] = 2'b10;
        run_stream(4, 0, "single_err");
        check_err(1, "single_err");
    endtask

    task automatic test_random_two_errors();
        do_reset();
        clear_stim();
        for (int i = 0; i < 200; i++) data_a[i] = 1'($urandom_range(0, 1));
        err_a[50] = 2'b01;
        err_a[58] = 2'b10;
        run_stream(200, 0, "random");
        check_err(2, "random");
    endtask

    task automatic test_gaps();
        do_reset();
        clear_stim();
        data_a[0] = 1; data_a[1] = 0; data_a[2] = 1; data_a[3] = 1;
        for (int i = 4; i < 24; i++) data_a[i] = 1'($urandom_range(0, 1));
        run_stream(24, 3, "gaps");
        check_err(0, "gaps");
    endtask

    task automatic test_reset_mid_stream();
        logic [1:0] st;
        bit b;
        do_reset();
        st = 2'b11;
        for (int k = 0; k < 10; k++) begin
            b = 1'($urandom_range(0, 1));
            send(enc(st, b), 1'b0, 1'b0, 0);
            st = {b, st[1]};
        end
        do_reset();
        check_err(0, "reset_mid_clear");
        clear_stim();
        data_a[0] = 0; data_a[1] = 1; data_a[2] = 1; data_a[3] = 0; data_a[4] = 1;
        run_stream(5, 0, "reset_mid");
        check_err(0, "reset_mid");
    endtask

    initial begin
        reset = 1'b0;
        sym_valid = 1'b0;
        sym = 2'b00;
        test_clean();
        test_reset();
        test_single_error();
        test_random_two_errors();
        test_gaps();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
